// File: rtl/apb_wait_slave_if.sv
// APB3 bus bundle for apb_wait_slave: requester-driven request signals plus the
// registered completer response.
interface apb_wait_slave_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_wait_slave.sv
// APB3 completer with a fixed number of wait states, 14 R/W registers, a
// completed-transfer counter and a constant ID register.
module apb_wait_slave #(
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_wait_slave_if.slave bus
);

    localparam logic [31:0]       IdValue  = 32'hA9B0_0001;
    localparam logic [DWIDTH-1:0] IdWord   = DWIDTH'(IdValue);
    localparam logic [3:0]        WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [3:0]        CntIdx   = 4'd14;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic              write_q, write_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DWIDTH-1:0] prdata_q, prdata_d;
    logic [DWIDTH-1:0] regs_q [14];
    logic [DWIDTH-1:0] xfer_cnt_q;

    logic              setup;
    logic [3:0]        live_idx;
    logic              live_err;
    logic              enter_resp;
    logic              commit;
    logic              count_up;
    logic [3:0]        resp_idx;
    logic              resp_write;
    logic              resp_err;
    logic [DWIDTH-1:0] rd_word;

    assign setup    = bus.PSEL && !bus.PENABLE;
    assign live_idx = bus.PADDR[5:2];
    assign live_err = (bus.PADDR[1:0] != 2'b00) || ((bus.PADDR >> 6) != '0) ||
                      (bus.PWRITE && (live_idx >= CntIdx));

    // With zero wait states the response is formed in the setup cycle itself, so it
    // must come from the live bus; otherwise from the values latched at setup.
    assign resp_idx   = (state_q == StIdle) ? live_idx    : idx_q;
    assign resp_write = (state_q == StIdle) ? bus.PWRITE  : write_q;
    assign resp_err   = (state_q == StIdle) ? live_err    : err_q;

    always_comb begin
        rd_word = '0;
        if (resp_idx < CntIdx) begin
            rd_word = regs_q[resp_idx];
        end else if (resp_idx == CntIdx) begin
            rd_word = xfer_cnt_q;
        end else begin
            rd_word = IdWord;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        commit     = 1'b0;
        count_up   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    idx_d   = live_idx;
                    write_d = bus.PWRITE;
                    wdata_d = bus.PWDATA;
                    err_d   = live_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = WaitLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!bus.PSEL) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                // A requester that drops PSEL here has abandoned the transfer.
                if (bus.PSEL && !err_q) begin
                    commit   = write_q;
                    count_up = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (enter_resp) begin
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            if (!resp_write && !resp_err) begin
                prdata_d = rd_word;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            idx_q     <= 4'd0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < 14; i++) begin
                regs_q[i] <= '0;
            end
            xfer_cnt_q <= '0;
        end else begin
            if (commit) begin
                regs_q[idx_q] <= wdata_q;
            end
            if (count_up) begin
                xfer_cnt_q <= xfer_cnt_q + DWIDTH'(1);
            end
        end
    end

    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Bench for apb_wait_slave: a 2-wait-state instance checked every cycle against a
// transaction-level model, plus a zero-wait instance with directed checks.
module tb_apb_wait_slave;

    localparam int          W  = 2;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_wait_slave_if #(.AWIDTH(32), .DWIDTH(32)) b2 ();
    apb_wait_slave_if #(.AWIDTH(32), .DWIDTH(32)) b0 ();

    apb_wait_slave #(.AWIDTH(32), .DWIDTH(32), .WAIT_CYCLES(2)) u2 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (b2.slave)
    );

    apb_wait_slave #(.AWIDTH(32), .DWIDTH(32), .WAIT_CYCLES(0)) u0 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (b0.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Pending expectation for the W=2 instance: one response due in cycle 'due'.
    bit          pend = 1'b0;
    int          due  = -1;
    bit          e_err;
    logic [31:0] e_rdata;
    bit          cmp_en = 1'b0;
    bit          exp_r;

    int          rdy_cyc;
    int          t0_last;
    logic [31:0] obs_rdata;
    logic        obs_err;

    logic [31:0] mreg [14];
    logic [31:0] mcnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit m_err(input bit wr, input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:6] != 26'd0) || (wr && (a[5:2] >= 4'd14));
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[5:2] < 4'd14) return mreg[a[5:2]];
        if (a[5:2] == 4'd14) return mcnt;
        return ID;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 14; i++) mreg[i] = 32'd0;
        mcnt = 32'd0;
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (cmp_en && !PRESET) begin
            exp_r = pend && (cyc == due);
            chk("pready", {31'd0, b2.PREADY}, {31'd0, exp_r});
            chk("pslverr", {31'd0, b2.PSLVERR}, exp_r ? {31'd0, e_err} : 32'd0);
            chk("prdata", b2.PRDATA, exp_r ? e_rdata : 32'd0);
            if (b2.PREADY === 1'b1) begin
                rdy_cyc   = cyc;
                obs_rdata = b2.PRDATA;
                obs_err   = b2.PSLVERR;
            end
        end
    end

    // Entered at posedge+1 of the setup cycle; returns at posedge+1 of the next free cycle.
    // cut: 0 = complete, 1 = drop PSEL in access cycle cut_at, 2 = pulse reset there.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int cut, input int cut_at);
        bit          e;
        logic [31:0] rd;
        b2.PSEL    = 1'b1;
        b2.PENABLE = 1'b0;
        b2.PWRITE  = wr;
        b2.PADDR   = a;
        b2.PWDATA  = d;
        e          = m_err(wr, a);
        rd         = (!wr && !e) ? m_read(a) : 32'd0;
        t0_last    = cyc;
        rdy_cyc    = -1;
        if (cut != 1) begin
            pend    = 1'b1;
            due     = cyc + 1 + W;
            e_err   = e;
            e_rdata = rd;
        end
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge PCLK); #1;
            b2.PENABLE = 1'b1;
            b2.PADDR   = $urandom;
            b2.PWDATA  = $urandom;
            b2.PWRITE  = !wr;
            if (cut == 1 && k == cut_at) begin
                b2.PSEL    = 1'b0;
                b2.PENABLE = 1'b0;
                @(posedge PCLK); #1;
                return;
            end
            if (cut == 2 && k == cut_at) begin
                #2;
                if (k == W + 1) chk("pre_rst_pready", {31'd0, b2.PREADY}, 32'd1);
                PRESET = 1'b1;
                #1;
                chk("rst_pready", {31'd0, b2.PREADY}, 32'd0);
                chk("rst_pslverr", {31'd0, b2.PSLVERR}, 32'd0);
                chk("rst_prdata", b2.PRDATA, 32'd0);
                pend = 1'b0;
                m_reset();
                b2.PSEL    = 1'b0;
                b2.PENABLE = 1'b0;
                @(posedge PCLK); #1;
                PRESET = 1'b0;
                return;
            end
        end
        @(posedge PCLK); #1;
        if (!e) begin
            if (wr) mreg[a[5:2]] = d;
            mcnt++;
        end
        pend       = 1'b0;
        b2.PSEL    = 1'b0;
        b2.PENABLE = 1'b0;
    endtask

    task automatic apb0(input string nm, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_e);
        b0.PSEL    = 1'b1;
        b0.PENABLE = 1'b0;
        b0.PWRITE  = wr;
        b0.PADDR   = a;
        b0.PWDATA  = d;
        #3;
        chk({nm, "_setup_pready"}, {31'd0, b0.PREADY}, 32'd0);
        @(posedge PCLK); #1;
        b0.PENABLE = 1'b1;
        b0.PADDR   = $urandom;
        b0.PWDATA  = $urandom;
        #3;
        chk({nm, "_pready"}, {31'd0, b0.PREADY}, 32'd1);
        chk({nm, "_pslverr"}, {31'd0, b0.PSLVERR}, {31'd0, exp_e});
        chk({nm, "_prdata"}, b0.PRDATA, exp_rd);
        @(posedge PCLK); #1;
        b0.PSEL    = 1'b0;
        b0.PENABLE = 1'b0;
    endtask

    initial begin
        PRESET     = 1'b1;
        b2.PSEL    = 1'b0; b2.PENABLE = 1'b0; b2.PWRITE = 1'b0;
        b2.PADDR   = 32'd0; b2.PWDATA = 32'd0;
        b0.PSEL    = 1'b0; b0.PENABLE = 1'b0; b0.PWRITE = 1'b0;
        b0.PADDR   = 32'd0; b0.PWDATA = 32'd0;
        m_reset();
        #3;
        chk("init_pready", {31'd0, b2.PREADY}, 32'd0);
        chk("init_pslverr", {31'd0, b2.PSLVERR}, 32'd0);
        chk("init_prdata", b2.PRDATA, 32'd0);
        chk("init0_pready", {31'd0, b0.PREADY}, 32'd0);
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        cmp_en = 1'b1;

        // First setup in the first cycle out of reset, three good transfers.
        xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 0, 0);
        chk("w08_latency", rdy_cyc - t0_last, 32'd3);
        chk("w08_err", {31'd0, obs_err}, 32'd0);
        xfer(1'b0, 32'h08, 32'h0, 0, 0);
        chk("r08_latency", rdy_cyc - t0_last, 32'd3);
        chk("r08_data", obs_rdata, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h34, 32'hCAFE_F00D, 0, 0);
        xfer(1'b0, 32'h38, 32'h0, 0, 0);
        chk("cnt3", obs_rdata, 32'd3);
        chk("model_cnt3", e_rdata, 32'd3);
        xfer(1'b0, 32'h38, 32'h0, 0, 0);
        chk("cnt4_b2b", obs_rdata, 32'd4);
        chk("cnt4_latency", rdy_cyc - t0_last, 32'd3);

        // Error responses: out of range, read-only targets, misaligned.
        xfer(1'b1, 32'h40, 32'h99, 0, 0);
        chk("w40_err", {31'd0, obs_err}, 32'd1);
        xfer(1'b1, 32'h3C, 32'h1, 0, 0);
        chk("w3c_err", {31'd0, obs_err}, 32'd1);
        xfer(1'b1, 32'h38, 32'h7, 0, 0);
        chk("w38_err", {31'd0, obs_err}, 32'd1);
        xfer(1'b0, 32'h09, 32'h0, 0, 0);
        chk("r09_err", {31'd0, obs_err}, 32'd1);
        chk("r09_data", obs_rdata, 32'd0);
        xfer(1'b0, 32'h38, 32'h0, 0, 0);
        chk("cnt5_no_err_inc", obs_rdata, 32'd5);
        for (int i = 0; i < 14; i++) xfer(1'b0, 32'(i * 4), 32'h0, 0, 0);
        xfer(1'b0, 32'h00, 32'h0, 0, 0);
        chk("r00_untouched", obs_rdata, 32'd0);
        xfer(1'b0, 32'h34, 32'h0, 0, 0);
        chk("r34_data", obs_rdata, 32'hCAFE_F00D);
        xfer(1'b0, 32'h3C, 32'h0, 0, 0);
        chk("r3c_id", obs_rdata, ID);

        // Requester abandons a write during the wait phase.
        xfer(1'b1, 32'h04, 32'h55, 1, 2);
        chk("abort_no_pready", rdy_cyc, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h04, 32'h0, 0, 0);
        chk("abort_no_write", obs_rdata, 32'd0);

        // Stray access phase with no setup must leave the FSM idle.
        b2.PSEL = 1'b1; b2.PENABLE = 1'b1; b2.PWRITE = 1'b1; b2.PADDR = 32'h0C;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        b2.PSEL = 1'b0; b2.PENABLE = 1'b0;
        xfer(1'b0, 32'h0C, 32'h0, 0, 0);
        chk("stray_latency", rdy_cyc - t0_last, 32'd3);
        chk("stray_no_write", obs_rdata, 32'd0);

        // Reset pulses mid-transfer: in the wait phase, then in the response cycle.
        xfer(1'b1, 32'h0C, 32'h77, 2, 1);
        xfer(1'b0, 32'h08, 32'h0, 0, 0);
        chk("rst_w_reg_clear", obs_rdata, 32'd0);
        chk("rst_w_latency", rdy_cyc - t0_last, 32'd3);
        xfer(1'b0, 32'h38, 32'h0, 0, 0);
        chk("rst_w_cnt", obs_rdata, 32'd1);
        xfer(1'b1, 32'h10, 32'h1234, 2, 3);
        xfer(1'b0, 32'h10, 32'h0, 0, 0);
        chk("rst_r_no_write", obs_rdata, 32'd0);
        xfer(1'b0, 32'h38, 32'h0, 0, 0);
        chk("rst_r_cnt", obs_rdata, 32'd1);
        xfer(1'b1, 32'h10, 32'h0000_ABCD, 0, 0);
        xfer(1'b0, 32'h10, 32'h0, 0, 0);
        chk("post_rst_rw", obs_rdata, 32'h0000_ABCD);

        // Zero-wait instance: response in the first access cycle.
        apb0("z_id", 1'b0, 32'h3C, 32'h0, ID, 1'b0);
        apb0("z_w10", 1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
        apb0("z_r10", 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0);
        apb0("z_cnt", 1'b0, 32'h38, 32'h0, 32'd3, 1'b0);
        apb0("z_w3c", 1'b1, 32'h3C, 32'h1, 32'h0, 1'b1);

        @(posedge PCLK); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_wait_slave.md
APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

Interface
REQ-001 SHALL have parameter AWIDTH, default 32: width of PADDR.
REQ-002 SHALL have parameter DWIDTH, default 32: width of PWDATA/PRDATA.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, legal range 0..15: number of access-phase cycles with PREADY low before completion.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port PCLK, input, 1 bit: the clock; all logic on the rising edge.
REQ-006 SHALL have port PRESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port PSEL, input, 1 bit: slave select.
REQ-008 SHALL have port PENABLE, input, 1 bit: access phase indicator.
REQ-009 SHALL have port PWRITE, input, 1 bit: 1 means write, 0 means read.
REQ-010 SHALL have port PADDR, input, AWIDTH bits: byte address.
REQ-011 SHALL have port PWDATA, input, DWIDTH bits: write data.
REQ-012 SHALL have port PRDATA, output, DWIDTH bits: read data, registered.
REQ-013 SHALL have port PREADY, output, 1 bit: transfer completion, registered.
REQ-014 SHALL have port PSLVERR, output, 1 bit: error response, registered, valid only while PREADY=1.

Function
REQ-015 SHALL implement an APB3 responder with 16 registers REG[0..15], each DWIDTH bits wide.
REQ-016 SHALL select the register by word index PADDR[5:2].
REQ-017 SHALL flag a decode error when PADDR[1:0]!=0 or PADDR[AWIDTH-1:6]!=0.
REQ-018 SHALL treat REG[0..13] as read/write.
REQ-019 SHALL treat REG[14] as read-only: a completed-transfer counter.
REQ-020 SHALL treat REG[15] as read-only: a constant ID equal to 0xA9B00001, truncated or zero-extended to DWIDTH.
REQ-021 SHALL flag an error on any write to REG[14] or REG[15].
REQ-022 SHALL use an FSM with states IDLE, WAIT and RESP.
REQ-023 IDLE: on PSEL=1 and PENABLE=0, SHALL latch PADDR, PWRITE and PWDATA; go to RESP if WAIT_CYCLES=0, otherwise load the 4-bit counter with WAIT_CYCLES-1 and go to WAIT.
REQ-024 WAIT: SHALL decrement the counter each cycle and go to RESP at the edge where the counter equals 0.
REQ-025 RESP: SHALL drive PREADY=1 for exactly one cycle, then return to IDLE.
REQ-026 SHALL give latency such that, with setup in cycle T, PREADY=1 in cycle T+1+WAIT_CYCLES.
REQ-027 SHALL drive PREADY=0 in IDLE and WAIT.
REQ-028 SHALL, in RESP for a read, drive PRDATA with the addressed register; PRDATA SHALL be 0 in every other cycle and on an errored read.
REQ-029 SHALL, in RESP, drive PSLVERR=1 if a decode or read-only error was latched; PSLVERR SHALL be 0 in every other cycle.
REQ-030 SHALL commit a non-errored write at the rising edge that ends the RESP cycle, using the latched address and data, not the live bus.
REQ-031 SHALL never modify any register on an errored write.
REQ-032 SHALL increment REG[14] by 1 at the end of each RESP cycle with PSLVERR=0, wrapping from all-ones to 0.
REQ-033 SHALL return the pre-increment value of REG[14] when REG[14] itself is read.
REQ-034 Abort: if PSEL=0 in WAIT or RESP, SHALL return to IDLE next cycle with no write, no PREADY and no counter increment.
REQ-035 Back-to-back: a new setup in the cycle after RESP SHALL be accepted from IDLE with the same latency.
REQ-036 SHALL ignore PENABLE=1 seen in IDLE without a preceding setup; the FSM stays in IDLE.
REQ-037 SHALL ignore changes to PADDR, PWRITE or PWDATA after setup for the current transfer.

Reset
REQ-038 SHALL, while PRESET=1, immediately force state=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, REG[0..14]=0.
REQ-039 SHALL keep REG[15] at the constant ID through reset.
REQ-040 SHALL, on reset asserted mid-transfer, drop the transfer with no write and no PREADY after release.
REQ-041 SHALL accept the first setup after reset release in the first cycle with PRESET=0.

Verification
REQ-042 SHALL verify: WAIT_CYCLES=2, write 0xDEADBEEF to 0x08 with setup at T -> PREADY=1 only at T+3, PSLVERR=0; read of 0x08 -> PRDATA=0xDEADBEEF at T'+3.
REQ-043 SHALL verify: WAIT_CYCLES=0, read of 0x3C -> PREADY=1 in the first access cycle, PRDATA=0xA9B00001.
REQ-044 SHALL verify: write to 0x40 and write to 0x3C -> PSLVERR=1 with PREADY; a subsequent read of REG[0..13] shows no change; REG[14] is not incremented.
REQ-045 SHALL verify: three good transfers after reset, then read of 0x38 -> PRDATA=3; a read immediately after -> PRDATA=4.
REQ-046 SHALL verify: PSEL dropped in WAIT during a write of 0x55 to 0x04 -> no PREADY; a later read of 0x04 returns 0.
REQ-047 SHALL verify: PRESET pulsed during WAIT of a write -> outputs 0 asynchronously; after release REG[0..14]=0 and the next transfer completes normally.
